// File: rtl/blur_coeff_sequencer.sv
// blur_coeff_sequencer
// Recomputes the 5-tap symmetric Gaussian blur kernel once per frame during
// vertical blanking. A shared exponent unit produces the raw tap weights, a
// shared divider normalises them against the accumulated kernel sum, and the
// finished set is copied into coeffs in a single cycle so the blur datapath
// never sees a half-updated kernel.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   h_count, v_count      raster position of the blur output stream
//   cutoff, force_update  control-panel blur setting / recompute request
//   exp_in_valid/value    request to the shared exponent unit
//   exp_out_valid/value   exponent unit result
//   div_in_valid, dividend, divisor, div_busy, div_out_valid, quotient
//                         request/result handshake with the shared divider
//   coeffs                committed taps, tap i at [8*i +: 8], tap 0 = centre
//   coeffs_updated        one-cycle pulse when a new set is committed
//   busy                  sequencer is not idle
//   error                 sticky: a shared unit failed to answer in time
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for the blanking trigger
// EXP_REQ  | issue exponent request for tap k
// EXP_WAIT | waiting for the exponent result of tap k
// DIV_REQ  | waiting for the divider to be free, then issue tap k
// DIV_WAIT | waiting for the quotient of tap k
// COMMIT   | shadow set complete, waiting for blanking to publish it

module blur_coeff_sequencer #(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic [9:0]  cutoff,
  input  logic        force_update,
  output logic        exp_in_valid,
  output logic [12:0] exp_in_value,
  input  logic        exp_out_valid,
  input  logic [7:0]  exp_out_value,
  output logic        div_in_valid,
  output logic [15:0] dividend,
  output logic [15:0] divisor,
  input  logic        div_busy,
  input  logic        div_out_valid,
  input  logic [15:0] quotient,
  output logic [39:0] coeffs,
  output logic        coeffs_updated,
  output logic        busy,
  output logic        error
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [39:0] COEFF_RESET = 40'h01_08_1B_38_48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP_REQ,
    S_EXP_WAIT,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_COMMIT
  } state_t;

  state_t state, state_next;

  logic [2:0]        k;
  logic [10:0]       mult;
  logic [7:0]        shadow [5];
  logic [11:0]       sum;
  logic [9:0]        cutoff_q;
  logic              have_cutoff;
  logic              force_pending;
  logic [WAIT_W-1:0] wait_cnt;

  logic at_trigger, in_blanking, wait_done;
  logic launch, take_exp, fire_div, take_div, do_commit, abort, load_wait;

  assign at_trigger  = (h_count == 11'(H_ACTIVE)) && (v_count == 10'(V_ACTIVE));
  assign in_blanking = (v_count >= 10'(V_ACTIVE));
  assign wait_done   = (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    take_exp   = 1'b0;
    fire_div   = 1'b0;
    take_div   = 1'b0;
    do_commit  = 1'b0;
    abort      = 1'b0;
    load_wait  = 1'b0;
    case (state)
      S_IDLE: begin
        if (at_trigger && (!have_cutoff || (cutoff != cutoff_q) || force_pending)) begin
          launch     = 1'b1;
          state_next = S_EXP_REQ;
        end
      end
      S_EXP_REQ: begin
        load_wait  = 1'b1;
        state_next = S_EXP_WAIT;
      end
      S_EXP_WAIT: begin
        if (exp_out_valid) begin
          take_exp = 1'b1;
          if (k == 3'd4) begin
            load_wait  = 1'b1;
            state_next = S_DIV_REQ;
          end else begin
            state_next = S_EXP_REQ;
          end
        end else if (wait_done) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DIV_REQ: begin
        if (!div_busy) begin
          fire_div   = 1'b1;
          state_next = S_DIV_WAIT;
        end else if (wait_done) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DIV_WAIT: begin
        if (div_out_valid) begin
          take_div = 1'b1;
          if (k == 3'd4) begin
            state_next = S_COMMIT;
          end else begin
            load_wait  = 1'b1;
            state_next = S_DIV_REQ;
          end
        end else if (wait_done) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (in_blanking) begin
          do_commit  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_in_valid   <= 1'b0;
      exp_in_value   <= '0;
      div_in_valid   <= 1'b0;
      dividend       <= '0;
      divisor        <= '0;
      coeffs         <= COEFF_RESET;
      coeffs_updated <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
      k              <= '0;
      mult           <= '0;
      sum            <= '0;
      cutoff_q       <= '0;
      have_cutoff    <= 1'b0;
      force_pending  <= 1'b0;
      wait_cnt       <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
    end else begin
      exp_in_valid   <= (state == S_EXP_REQ);
      div_in_valid   <= fire_div;
      coeffs_updated <= do_commit;
      busy           <= (state_next != S_IDLE);

      // A request arriving on the launch cycle must survive for the next frame.
      if (launch)       force_pending <= 1'b0;
      if (force_update) force_pending <= 1'b1;

      if (launch) begin
        cutoff_q  <= cutoff;
        mult      <= 11'h080 + {2'b00, cutoff[9:1]};
        shadow[0] <= 8'hFF;
        sum       <= 12'h100;
        k         <= 3'd1;
      end

      if (state == S_EXP_REQ) exp_in_value <= {2'b00, mult} * {10'b0, k};

      if (take_exp) begin
        shadow[k] <= exp_out_value;
        sum       <= sum + {3'b000, exp_out_value, 1'b0};
        k         <= (k == 3'd4) ? 3'd0 : k + 3'd1;
      end

      if (fire_div) begin
        dividend <= {shadow[k], 8'h00};
        divisor  <= {4'h0, sum};
      end

      if (take_div) begin
        shadow[k] <= (quotient > 16'd255) ? 8'hFF : quotient[7:0];
        if (k != 3'd4) k <= k + 3'd1;
      end

      if (do_commit) begin
        coeffs      <= {shadow[4], shadow[3], shadow[2], shadow[1], shadow[0]};
        have_cutoff <= 1'b1;
      end

      if (abort) error <= 1'b1;

      // One budget per exponent tap; DIV_REQ and DIV_WAIT share one per tap.
      if (load_wait)
        wait_cnt <= WAIT_TOP;
      else if ((state == S_EXP_WAIT || state == S_DIV_REQ || state == S_DIV_WAIT) && !wait_done)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_blur_coeff_sequencer.sv
// Self-checking bench for blur_coeff_sequencer. Behavioural exponent and
// divider units answer requests with random latency; expected coefficients
// are derived from the returned exponent values with plain arithmetic.

module tb_blur_coeff_sequencer;

  localparam logic [39:0] COEFF_RESET = 40'h01_08_1B_38_48;

  logic        clk, rst_n;
  logic [10:0] h_count;
  logic [9:0]  v_count, cutoff;
  logic        force_update;
  logic        exp_in_valid, exp_out_valid;
  logic [12:0] exp_in_value;
  logic [7:0]  exp_out_value;
  logic        div_in_valid, div_busy, div_out_valid;
  logic [15:0] dividend, divisor, quotient;
  logic [39:0] coeffs;
  logic        coeffs_updated, busy, error;

  blur_coeff_sequencer dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .cutoff(cutoff), .force_update(force_update),
    .exp_in_valid(exp_in_valid), .exp_in_value(exp_in_value),
    .exp_out_valid(exp_out_valid), .exp_out_value(exp_out_value),
    .div_in_valid(div_in_valid), .dividend(dividend), .divisor(divisor),
    .div_busy(div_busy), .div_out_valid(div_out_valid), .quotient(quotient),
    .coeffs(coeffs), .coeffs_updated(coeffs_updated), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // environment state
  logic [12:0] exp_log [$];
  logic [7:0]  exp_ret [$];
  logic [7:0]  exp_fixed [$];
  logic [15:0] dd_log [$];
  logic [15:0] ds_log [$];
  bit exp_mute = 0, div_mute = 0, div_release = 1;
  int div_hold_idx = -1;
  int upd_cnt = 0;

  // exponent unit model
  bit exp_armed = 0;
  int exp_cnt = 0;
  always @(negedge clk) begin
    exp_out_valid = 1'b0;
    if (exp_in_valid) begin
      exp_log.push_back(exp_in_value);
      if (!exp_mute) begin
        exp_armed = 1;
        exp_cnt   = $urandom_range(0, 5);
      end
    end
    if (exp_armed) begin
      if (exp_cnt == 0) begin
        exp_out_value = (exp_fixed.size() > 0) ? exp_fixed.pop_front() : 8'($urandom_range(0, 255));
        exp_ret.push_back(exp_out_value);
        exp_out_valid = 1'b1;
        exp_armed     = 0;
      end else exp_cnt--;
    end
  end

  // divider model
  bit div_armed = 0;
  int div_cnt = 0, div_n = 0;
  logic [15:0] cur_dd, cur_ds;
  always @(negedge clk) begin
    div_out_valid = 1'b0;
    if (div_in_valid) begin
      dd_log.push_back(dividend);
      ds_log.push_back(divisor);
      div_n++;
      cur_dd = dividend;
      cur_ds = divisor;
      if (!div_mute) begin
        div_armed = 1;
        div_cnt   = $urandom_range(0, 5);
      end
    end
    if (div_armed && !(div_n == div_hold_idx && !div_release)) begin
      if (div_cnt == 0) begin
        quotient      = (cur_ds == 0) ? 16'hFFFF : cur_dd / cur_ds;
        div_out_valid = 1'b1;
        div_armed     = 0;
      end else div_cnt--;
    end
  end

  always @(negedge clk) if (coeffs_updated) upd_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Kernel expected from the exponent values returned for this run.
  function automatic logic [39:0] model_coeffs();
    int e [5];
    int s;
    logic [39:0] r;
    e[0] = 255;
    s = 256;
    for (int i = 0; i < 4; i++) begin
      e[i+1] = int'(exp_ret[i]);
      s += 2 * e[i+1];
    end
    for (int t = 0; t < 5; t++) begin
      int q;
      q = (e[t] * 256) / s;
      if (q > 255) q = 255;
      r[8*t +: 8] = 8'(q);
    end
    return r;
  endfunction

  int upd_before;
  logic [9:0] run_cut;

  task automatic start_run(input logic [9:0] cut);
    exp_log.delete(); exp_ret.delete(); dd_log.delete(); ds_log.delete();
    div_n = 0;
    upd_before = upd_cnt;
    run_cut = cut;
    cutoff = cut;
    tick(1);
    h_count = 11'd1280; v_count = 10'd720;
    tick(1);
    h_count = 11'd0;
  endtask

  task automatic expect_commit(input string tag);
    bit got;
    logic [39:0] m;
    int sum_m;
    got = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      tick(1);
      if (coeffs_updated) got = 1;
    end
    check({tag, "_pulse"}, got, 1'b1);
    check({tag, "_exp_reqs"}, exp_log.size(), 4);
    check({tag, "_div_reqs"}, ds_log.size(), 5);
    for (int i = 0; i < 4; i++)
      if (i < exp_log.size())
        check({tag, "_exp_in_value"}, exp_log[i], (13'h080 + 13'(run_cut >> 1)) * 13'(i + 1));
    if (exp_ret.size() == 4) begin
      m = model_coeffs();
      sum_m = 256;
      for (int i = 0; i < 4; i++) sum_m += 2 * int'(exp_ret[i]);
      for (int i = 0; i < 5; i++)
        if (i < ds_log.size()) begin
          check({tag, "_divisor"}, ds_log[i], 16'(sum_m));
          check({tag, "_dividend"}, dd_log[i], {(i == 0) ? 8'hFF : exp_ret[i-1], 8'h00});
        end
      check({tag, "_coeffs"}, coeffs, m);
    end
    tick(4);
    check({tag, "_one_pulse"}, upd_cnt - upd_before, 1);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    bit seen, stable;
    logic [39:0] held;
    rst_n = 1'b0; h_count = 0; v_count = 0; cutoff = 0; force_update = 0; div_busy = 0;
    tick(3);
    check("rst_coeffs", coeffs, COEFF_RESET);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_strobes", {exp_in_valid, div_in_valid, coeffs_updated}, 3'b000);
    rst_n = 1'b1;
    tick(2);

    // exponent unit never answers: timeout aborts the run
    exp_mute = 1;
    start_run(10'($urandom_range(1, 1022)));
    for (int c = 0; c < 20 && exp_log.size() == 0; c++) tick(1);
    check("to_req_seen", exp_log.size(), 1);
    tick(990);
    check("to_not_early", {busy, error}, 2'b10);
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin tick(1); seen = error; end
    check("to_error", error, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_coeffs", coeffs, COEFF_RESET);
    check("to_no_pulse", upd_cnt, 0);
    exp_mute = 0;

    // directed kernel: cutoff 0, fixed exponent answers
    exp_fixed = '{8'hC0, 8'h80, 8'h40, 8'h10};
    start_run(10'd0);
    expect_commit("t1");
    check("t1_divisor_1056", (ds_log.size() > 0) ? ds_log[0] : 16'hxxxx, 16'd1056);
    check("t1_coeffs_const", coeffs, 40'h03_0F_1F_2E_3D);

    // same cutoff, no force: nothing happens
    held = coeffs;
    start_run(10'd0);
    tick(30);
    check("t2_no_exp", exp_log.size(), 0);
    check("t2_no_pulse", upd_cnt - upd_before, 0);
    check("t2_coeffs", coeffs, held);

    // force during active video, recompute at next trigger
    v_count = 10'd100;
    force_update = 1; tick(1); force_update = 0;
    tick(3);
    check("t2_force_wait", busy, 1'b0);
    start_run(10'd0);
    expect_commit("force");

    start_run(10'h3FF);
    expect_commit("max_cut");

    // divider busy for 50 cycles
    div_busy = 1;
    start_run(10'($urandom_range(1, 1022)));
    for (int c = 0; c < 200 && exp_ret.size() < 4; c++) tick(1);
    tick(3);
    seen = 0;
    for (int c = 0; c < 50; c++) begin tick(1); seen |= div_in_valid; end
    check("busy_hold_no_req", seen, 1'b0);
    div_busy = 0;
    tick(1);
    check("busy_release_req", div_in_valid, 1'b1);
    expect_commit("busy");

    // final quotient arrives in active video: commit deferred
    div_hold_idx = 5; div_release = 0;
    start_run(run_cut ^ 10'h155);
    for (int c = 0; c < 400 && dd_log.size() < 5; c++) tick(1);
    check("defer_reqs", dd_log.size(), 5);
    held = coeffs;
    v_count = 10'd5;
    div_release = 1;
    stable = 1;
    for (int v = 5; v < 720; v++) begin
      v_count = 10'(v);
      tick(1);
      if (coeffs !== held || coeffs_updated) stable = 0;
    end
    check("defer_stable", stable, 1'b1);
    check("defer_busy", busy, 1'b1);
    v_count = 10'd720;
    tick(1);
    check("defer_pulse", coeffs_updated, 1'b1);
    check("defer_coeffs", coeffs, (exp_ret.size() == 4) ? model_coeffs() : 40'hx);
    div_hold_idx = -1;
    tick(3);
    check("error_sticky", error, 1'b1);

    // async reset in the middle of DIV_WAIT
    div_mute = 1;
    start_run(run_cut ^ 10'h2AA);
    for (int c = 0; c < 300 && dd_log.size() == 0; c++) tick(1);
    tick(2);
    check("rst_mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_coeffs", coeffs, COEFF_RESET);
    check("arst_busy", busy, 1'b0);
    check("arst_error", error, 1'b0);
    check("arst_strobes", {exp_in_valid, div_in_valid, coeffs_updated}, 3'b000);
    tick(2);
    rst_n = 1'b1;
    div_mute = 0;
    tick(2);
    check("post_rst_idle", {busy, error}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blur_coeff_sequencer.md
Name: blur_coeff_sequencer

Overview:
Controller that recomputes the 5-tap symmetric Gaussian blur coefficients once per frame during vertical blanking. It sequences a shared exponent unit and a shared 16-bit divider through valid/busy handshakes and accumulates the normalisation sum. It commits the new coefficient set atomically, so the separable blur datapath never sees a partially updated kernel. It sits between the control-panel parameters (cutoff) and the video blur datapath's coefficient input.

Parameters:
H_ACTIVE, 1280, first non-active h_count; start-of-blanking trigger column
V_ACTIVE, 720, first non-active v_count; trigger row and commit gate
TIMEOUT_CYCLES, 1023, maximum cycles spent waiting on either shared unit before aborting

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  reset, asynchronous, active-low
h_count  in  11  pixel column of the blur output stream
v_count  in  10  pixel row of the blur output stream
cutoff  in  10  blur cutoff control
force_update  in  1  single-cycle request to recompute even if cutoff is unchanged
exp_in_valid  out  1  request strobe to exponent unit
exp_in_value  out  13  exponent argument
exp_out_valid  in  1  exponent result strobe
exp_out_value  in  8  exponent result
div_in_valid  out  1  request strobe to divider
dividend  out  16  divider numerator
divisor  out  16  divider denominator
div_busy  in  1  divider occupied
div_out_valid  in  1  divider result strobe
quotient  in  16  divider result
coeffs  out  5x8  committed coefficients; index 0 is the centre tap
coeffs_updated  out  1  one-cycle pulse on commit
busy  out  1  high in any state other than IDLE
error  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE; coeffs = {0x48,0x38,0x1B,0x08,0x01} for taps 0..4; exp_in_valid, div_in_valid, coeffs_updated, busy and error = 0; force_pending = 0; have_cutoff = 0.
- force_update sets force_pending. force_pending clears only when a recompute is launched.
- Trigger: in IDLE, on the cycle h_count==H_ACTIVE && v_count==V_ACTIVE, launch if !have_cutoff || cutoff!=cutoff_q || force_pending. Otherwise stay in IDLE. Triggers outside IDLE are ignored.
- On launch:
  - cutoff_q <= cutoff
  - mult (11 bit) = 0x080 + (cutoff>>1)
  - shadow[0] = 0xFF
  - sum (12 bit) = 0x100
  - k = 1
- States:
  - IDLE
  - EXP_REQ: exp_in_valid=1 for exactly one cycle, exp_in_value = mult*k (13 bit, no overflow possible); goes to EXP_WAIT.
  - EXP_WAIT: on exp_out_valid, shadow[k]=exp_out_value and sum += 2*exp_out_value. If k==4, go to DIV_REQ with k=0; else k++ and go to EXP_REQ.
  - DIV_REQ: wait while div_busy. Once !div_busy, pulse div_in_valid for one cycle with dividend={shadow[k],8'h00} and divisor={4'h0,sum}; go to DIV_WAIT.
  - DIV_WAIT: on div_out_valid, shadow[k] = quotient>255 ? 0xFF : quotient[7:0]. If k==4, go to COMMIT; else k++ and go to DIV_REQ.
  - COMMIT: only when v_count>=V_ACTIVE, copy all five shadow values into coeffs in the same cycle, pulse coeffs_updated, set have_cutoff=1 and go to IDLE. If v_count<V_ACTIVE, hold in COMMIT until the next blanking period; coeffs never change during active video.
- Timeout: a wait counter resets on entry to EXP_WAIT or DIV_REQ. If it reaches TIMEOUT_CYCLES (DIV_REQ/DIV_WAIT share one budget per tap), then:
  - go to IDLE and set error=1;
  - leave coeffs unchanged and produce no coeffs_updated;
  - leave have_cutoff unchanged, so the same cutoff retries next frame.
- error clears only on reset.
- Result strobes arriving in a state that is not waiting for them are ignored.
- Only one request is ever outstanding.
- Outputs are registered. dividend, divisor and exp_in_value hold their value after the strobe.

Test Plan:
- Release reset, cutoff=0, reach (1280,720), exp model returns 0xC0,0x80,0x40,0x10 -> exp_in_value sequence 0x080,0x100,0x180,0x200; divisor=1056; committed coeffs = 0x3D,0x2E,0x1F,0x0F,0x03; one coeffs_updated pulse.
- Next frame, same cutoff, no force -> no exp_in_valid, coeffs unchanged, no pulse. Then force_update during active video -> recompute at the next (1280,720).
- cutoff=0x3FF -> exp_in_value sequence 0x27F,0x4FE,0x77D,0x9FC.
- Hold div_busy=1 for 50 cycles in DIV_REQ -> div_in_valid stays 0 until the cycle after div_busy falls. Exp model never answers -> error=1 and busy=0 after TIMEOUT_CYCLES; coeffs still at the reset set.
- Delay the final div_out_valid until v_count=5 -> commit deferred to the next v_count=720; coeffs stable during rows 5..719.
- Assert rst_n low mid DIV_WAIT -> outputs take reset values immediately, without a clock edge; busy=0.
